// File: rtl/iob_soc_ext_mem_preload.sv
// Boot-time ROM-to-RAM image preloader that owns the external RAM port until the copy
// finishes, then passes the SoC memory bus straight through to the RAM.
module iob_soc_ext_mem_preload #(
    parameter int DATA_W     = 32,
    parameter int ROM_ADDR_W = 10,
    parameter int RAM_ADDR_W = 13,
    parameter int ROM_BASE   = 0,
    parameter int RAM_BASE   = 0,
    parameter int COPY_LEN   = 1024,
    parameter int AUTO_START = 1
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  soc_hold_o,
    output logic [1:0]            dbg_state_o,
    output logic                  rom_en_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0]     rom_r_data_i,
    input  logic                  soc_r_en_i,
    input  logic [RAM_ADDR_W-1:0] soc_r_addr_i,
    input  logic [DATA_W-1:0]     soc_w_data_i,
    input  logic [DATA_W/8-1:0]   soc_w_strb_i,
    input  logic [RAM_ADDR_W-1:0] soc_w_addr_i,
    output logic [DATA_W-1:0]     soc_r_data_o,
    output logic                  ram_r_en_o,
    output logic [RAM_ADDR_W-1:0] ram_r_addr_o,
    output logic [DATA_W-1:0]     ram_w_data_o,
    output logic [DATA_W/8-1:0]   ram_w_strb_o,
    output logic [RAM_ADDR_W-1:0] ram_w_addr_o,
    input  logic [DATA_W-1:0]     ram_r_data_i
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_COPY  = 2'd1,
        ST_PASS  = 2'd2
    } state_t;

    // One extra bit so the phase counter can reach COPY_LEN = 2^ROM_ADDR_W.
    localparam int PW = ROM_ADDR_W + 1;
    localparam logic [PW-1:0] LEN_P = PW'(COPY_LEN);
    localparam logic [PW-1:0] ONE_P = PW'(1);
    localparam state_t RST_STATE = (AUTO_START != 0) ? ST_START : ST_PASS;
    localparam logic RST_HOLD = (AUTO_START != 0);
    localparam logic [ROM_ADDR_W-1:0] ROM_BASE_A = ROM_ADDR_W'(ROM_BASE);
    localparam logic [RAM_ADDR_W-1:0] RAM_BASE_A = RAM_ADDR_W'(RAM_BASE);

    state_t          state_q, state_d;
    logic [PW-1:0]   p_q, p_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            hold_q, hold_d;

    logic                  in_copy;
    logic                  in_pass;
    logic                  copy_rd;
    logic                  copy_wr;
    logic [RAM_ADDR_W-1:0] copy_w_addr;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        done_d  = done_q;
        case (state_q)
            ST_START: begin
                p_d = '0;
                if (COPY_LEN == 0) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                if (p_q == LEN_P) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                end else begin
                    p_d = p_q + ONE_P;
                end
            end
            ST_PASS: begin
                if (start_i) begin
                    state_d = ST_START;
                    done_d  = 1'b0;
                end
            end
            default: state_d = RST_STATE;
        endcase
        busy_d = (state_d == ST_COPY);
        hold_d = (state_d != ST_PASS);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= RST_STATE;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= RST_HOLD;
        end else if (cke_i) begin
            state_q <= state_d;
            p_q     <= p_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign soc_hold_o  = hold_q;
    assign dbg_state_o = state_q;

    // Copy pipeline: word p is read while word p-1 (held in the ROM output
    // register) is written; both sides freeze while cke_i is low.
    assign in_copy     = (state_q == ST_COPY);
    assign in_pass     = (state_q == ST_PASS);
    assign copy_rd     = in_copy && cke_i && (p_q < LEN_P);
    assign copy_wr     = in_copy && cke_i && (p_q != '0);
    assign copy_w_addr = RAM_BASE_A + RAM_ADDR_W'(p_q - ONE_P);

    assign rom_en_o   = copy_rd;
    assign rom_addr_o = ROM_BASE_A + p_q[ROM_ADDR_W-1:0];

    assign ram_r_en_o   = in_pass && soc_r_en_i;
    assign ram_r_addr_o = in_pass ? soc_r_addr_i : '0;
    assign ram_w_data_o = in_pass ? soc_w_data_i : (in_copy ? rom_r_data_i : '0);
    assign ram_w_strb_o = in_pass ? soc_w_strb_i : (copy_wr ? '1 : '0);
    assign ram_w_addr_o = in_pass ? soc_w_addr_i : (in_copy ? copy_w_addr : '0);
    assign soc_r_data_o = in_pass ? ram_r_data_i : '0;

endmodule

// File: tb/tb_iob_soc_ext_mem_preload.sv
// Directed bench: three preloader instances (LEN=8 auto-start, LEN=0, and a manual-start
// copy that wraps the RAM address), each with simple ROM and byte-enable RAM models.
module tb_iob_soc_ext_mem_preload;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: LEN=8, ROM_BASE=0, RAM_BASE=0, auto start.
  logic        rst_a = 1'b1, cke_a = 1'b1, start_a = 1'b0;
  logic        busy_a, done_a, hold_a, rom_en_a, ram_r_en_a;
  logic [1:0]  dbg_a;
  logic [9:0]  rom_addr_a;
  logic [31:0] rom_data_a = '0, rom_off_a = '0;
  logic        soc_r_en_a = 1'b0;
  logic [12:0] soc_r_addr_a = '0, soc_w_addr_a = '0;
  logic [31:0] soc_w_data_a = '0;
  logic [3:0]  soc_w_strb_a = '0;
  logic [31:0] soc_r_data_a, ram_w_data_a, ram_rd_a = '0;
  logic [12:0] ram_r_addr_a, ram_w_addr_a;
  logic [3:0]  ram_w_strb_a;
  logic [31:0] mem_a [8192];
  int wr_cnt_a = 0, odd_strb_a = 0, busy_cnt_a = 0, leak_a = 0;

  // Instances B (LEN=0) and C (manual start, wrapping RAM base) share a reset.
  logic        rst_bc = 1'b1, one = 1'b1, zero = 1'b0, start_c = 1'b0;
  logic [12:0] zero13 = '0, soc_w_addr_c = 13'h0abc;
  logic [31:0] zero32 = '0;
  logic [3:0]  zero4 = '0;
  logic        busy_b, done_b, hold_b, rom_en_b, ram_r_en_b;
  logic [1:0]  dbg_b;
  logic [9:0]  rom_addr_b;
  logic [31:0] soc_r_data_b, ram_w_data_b;
  logic [12:0] ram_r_addr_b, ram_w_addr_b;
  logic [3:0]  ram_w_strb_b;
  int rom_cnt_b = 0, wr_cnt_b = 0;

  logic        busy_c, done_c, hold_c, rom_en_c, ram_r_en_c;
  logic [1:0]  dbg_c;
  logic [9:0]  rom_addr_c;
  logic [31:0] rom_data_c = '0, soc_r_data_c, ram_w_data_c;
  logic [12:0] ram_r_addr_c, ram_w_addr_c;
  logic [3:0]  ram_w_strb_c;
  logic [31:0] mem_c [8192];
  logic [12:0] got_c[$];
  logic [12:0] exp_q[$];

  iob_soc_ext_mem_preload #(.COPY_LEN(8)) dut_a (
    .clk_i(clk), .cke_i(cke_a), .arst_i(rst_a), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .soc_hold_o(hold_a), .dbg_state_o(dbg_a),
    .rom_en_o(rom_en_a), .rom_addr_o(rom_addr_a), .rom_r_data_i(rom_data_a),
    .soc_r_en_i(soc_r_en_a), .soc_r_addr_i(soc_r_addr_a), .soc_w_data_i(soc_w_data_a),
    .soc_w_strb_i(soc_w_strb_a), .soc_w_addr_i(soc_w_addr_a), .soc_r_data_o(soc_r_data_a),
    .ram_r_en_o(ram_r_en_a), .ram_r_addr_o(ram_r_addr_a), .ram_w_data_o(ram_w_data_a),
    .ram_w_strb_o(ram_w_strb_a), .ram_w_addr_o(ram_w_addr_a), .ram_r_data_i(ram_rd_a)
  );

  iob_soc_ext_mem_preload #(.COPY_LEN(0)) dut_b (
    .clk_i(clk), .cke_i(one), .arst_i(rst_bc), .start_i(zero),
    .busy_o(busy_b), .done_o(done_b), .soc_hold_o(hold_b), .dbg_state_o(dbg_b),
    .rom_en_o(rom_en_b), .rom_addr_o(rom_addr_b), .rom_r_data_i(zero32),
    .soc_r_en_i(zero), .soc_r_addr_i(zero13), .soc_w_data_i(zero32),
    .soc_w_strb_i(zero4), .soc_w_addr_i(zero13), .soc_r_data_o(soc_r_data_b),
    .ram_r_en_o(ram_r_en_b), .ram_r_addr_o(ram_r_addr_b), .ram_w_data_o(ram_w_data_b),
    .ram_w_strb_o(ram_w_strb_b), .ram_w_addr_o(ram_w_addr_b), .ram_r_data_i(zero32)
  );

  iob_soc_ext_mem_preload #(.COPY_LEN(4), .RAM_BASE(13'h1ffe), .AUTO_START(0)) dut_c (
    .clk_i(clk), .cke_i(one), .arst_i(rst_bc), .start_i(start_c),
    .busy_o(busy_c), .done_o(done_c), .soc_hold_o(hold_c), .dbg_state_o(dbg_c),
    .rom_en_o(rom_en_c), .rom_addr_o(rom_addr_c), .rom_r_data_i(rom_data_c),
    .soc_r_en_i(zero), .soc_r_addr_i(zero13), .soc_w_data_i(zero32),
    .soc_w_strb_i(zero4), .soc_w_addr_i(soc_w_addr_c), .soc_r_data_o(soc_r_data_c),
    .ram_r_en_o(ram_r_en_c), .ram_r_addr_o(ram_r_addr_c), .ram_w_data_o(ram_w_data_c),
    .ram_w_strb_o(ram_w_strb_c), .ram_w_addr_o(ram_w_addr_c), .ram_r_data_i(zero32)
  );

  // ROM models: one-cycle registered read, word i = base pattern + i.
  always @(posedge clk) begin
    if (rom_en_a) rom_data_a <= 32'ha5000000 + rom_off_a + 32'(rom_addr_a);
    if (rom_en_c) rom_data_c <= 32'hc0de0000 + 32'(rom_addr_c);
  end

  // RAM models and event counters.
  always @(posedge clk) begin
    if (ram_r_en_a) ram_rd_a <= mem_a[ram_r_addr_a];
    for (int b = 0; b < 4; b++) begin
      if (ram_w_strb_a[b]) mem_a[ram_w_addr_a][8*b +: 8] <= ram_w_data_a[8*b +: 8];
      if (ram_w_strb_c[b]) mem_c[ram_w_addr_c][8*b +: 8] <= ram_w_data_c[8*b +: 8];
    end
    if (|ram_w_strb_a) wr_cnt_a <= wr_cnt_a + 1;
    if (|ram_w_strb_a && ram_w_strb_a != 4'hf) odd_strb_a <= odd_strb_a + 1;
    if (busy_a && cke_a) busy_cnt_a <= busy_cnt_a + 1;
    if (hold_a && ram_r_en_a) leak_a <= leak_a + 1;
    if (rom_en_b) rom_cnt_b <= rom_cnt_b + 1;
    if (|ram_w_strb_b) wr_cnt_b <= wr_cnt_b + 1;
    if (|ram_w_strb_c) got_c.push_back(ram_w_addr_c);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_image(input string tag, input logic [31:0] off);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_w%0d", tag, i), mem_a[i], 32'ha5000000 + off + 32'(i));
  endtask

  initial begin
    int fall_a, done_b_cyc, done_c_cyc, base_busy, base_wr;
    fall_a = 0; done_b_cyc = 0; done_c_cyc = 0;
    // SoC traffic is driven during reset/copy to show it is blocked.
    soc_r_en_a = 1'b1; soc_r_addr_a = 13'd7;
    soc_w_strb_a = 4'hf; soc_w_addr_a = 13'd100; soc_w_data_a = 32'hdeadbeef;
    repeat (2) @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_hold_a", hold_a, 1);
    chk("rst_rom_en_a", rom_en_a, 0);
    chk("rst_w_strb_a", ram_w_strb_a, 0);
    chk("rst_r_en_a", ram_r_en_a, 0);
    chk("rst_rdata_a", soc_r_data_a, 0);
    chk("rst_hold_b", hold_b, 1);
    chk("rst_hold_c", hold_c, 0);
    chk("rst_done_c", done_c, 0);
    chk("rst_pass_addr_c", ram_w_addr_c, 32'h0abc);

    // Auto-start copy of 8 words; B finishes immediately with nothing copied.
    rst_a = 1'b0; rst_bc = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (!hold_a && fall_a == 0) fall_a = cyc;
      if (done_b && done_b_cyc == 0) done_b_cyc = cyc;
      if (cyc == 5) chk("copy_rdata_zero_a", soc_r_data_a, 0);
      if (cyc == 10) begin soc_w_strb_a = 4'h0; soc_r_en_a = 1'b0; end
    end
    chk("hold_fall_cyc_a", fall_a, 10);
    chk("done_a", done_a, 1);
    chk("busy_cycles_a", busy_cnt_a, 9);
    chk("writes_a", wr_cnt_a, 8);
    chk("odd_strb_a", odd_strb_a, 0);
    chk("rd_leak_a", leak_a, 0);
    chk_image("img1", 32'h0);
    chk("done_cyc_b", done_b_cyc, 1);
    chk("hold_b", hold_b, 0);
    chk("rom_reads_b", rom_cnt_b, 0);
    chk("writes_b", wr_cnt_b, 0);

    // Pass-through write then read of word 5.
    soc_w_data_a = 32'h12345678; soc_w_strb_a = 4'h3; soc_w_addr_a = 13'd5;
    #1;
    chk("pass_w_data", ram_w_data_a, 32'h12345678);
    chk("pass_w_strb", ram_w_strb_a, 4'h3);
    chk("pass_w_addr", ram_w_addr_a, 5);
    @(negedge clk);
    soc_w_strb_a = 4'h0; soc_r_en_a = 1'b1; soc_r_addr_a = 13'd5;
    #1;
    chk("pass_r_en", ram_r_en_a, 1);
    chk("pass_r_addr", ram_r_addr_a, 5);
    @(negedge clk);
    chk("pass_rdata", soc_r_data_a, 32'ha5005678);
    soc_r_en_a = 1'b0;

    // Manual start on C with a RAM base that wraps past the top of the RAM.
    exp_q = '{13'h1ffe, 13'h1fff, 13'h0000, 13'h0001};
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("start_hold_c", hold_c, 1);
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      if (done_c && done_c_cyc == 0) done_c_cyc = m;
    end
    chk("done_cyc_c", done_c_cyc, 6);
    chk("writes_c", got_c.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_c.size()) chk($sformatf("wr_addr_c%0d", i), got_c[i], exp_q[i]);
      chk($sformatf("img_c%0d", i), mem_c[exp_q[i]], 32'hc0de0000 + 32'(i));
    end

    // Restart A with a new image and stall cke for 3 cycles at p=4.
    rom_off_a = 32'h00100000;
    base_busy = busy_cnt_a; base_wr = wr_cnt_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("restart_done_clr_a", done_a, 0);
    chk("restart_hold_a", hold_a, 1);
    repeat (5) @(negedge clk);
    chk("p4_strb_a", ram_w_strb_a, 4'hf);
    cke_a = 1'b0;
    #1;
    chk("cke_lo_strb0", ram_w_strb_a, 0);
    chk("cke_lo_rom_en", rom_en_a, 0);
    @(negedge clk);
    chk("cke_lo_strb1", ram_w_strb_a, 0);
    @(negedge clk);
    chk("cke_lo_strb2", ram_w_strb_a, 0);
    @(negedge clk);
    cke_a = 1'b1;
    #1;
    chk("resume_strb", ram_w_strb_a, 4'hf);
    chk("resume_addr", ram_w_addr_a, 3);
    chk("resume_data", ram_w_data_a, 32'ha5100003);
    for (int i = 0; i < 20 && hold_a; i++) @(negedge clk);
    chk("cke_hold_a", hold_a, 0);
    chk("cke_busy_cycles", busy_cnt_a - base_busy, 9);
    chk("cke_writes", wr_cnt_a - base_wr, 8);
    chk_image("img2", 32'h00100000);

    // Asynchronous reset at p=3 aborts; the copy then reruns from word 0.
    rom_off_a = 32'h00200000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_strb", ram_w_strb_a, 4'hf);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_strb", ram_w_strb_a, 0);
    chk("arst_rom_en", rom_en_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_hold", hold_a, 1);
    chk("arst_state", dbg_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    base_busy = busy_cnt_a; base_wr = wr_cnt_a; fall_a = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 3) start_a = 1'b1;
      if (cyc == 4) start_a = 1'b0;
      if (!hold_a && fall_a == 0) fall_a = cyc;
    end
    chk("arst_hold_fall", fall_a, 10);
    chk("arst_busy_cycles", busy_cnt_a - base_busy, 9);
    chk("arst_writes", wr_cnt_a - base_wr, 8);
    chk("arst_done_end", done_a, 1);
    chk_image("img3", 32'h00200000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iob_soc_ext_mem_preload.md
# iob_soc_ext_mem_preload

Boot-time preloader and access multiplexer between the SoC external memory bus and the two-port byte-enable external RAM. After reset, or on request, it copies a contiguous word image from a synchronous single-port ROM into the RAM while holding the SoC off the RAM. It then hands the RAM port through to the SoC unchanged. It sits directly upstream of the external RAM, in parallel with the SoC memory bus.

## Interface
- DATA_W, 32, word width for ROM, RAM and SoC bus
- ROM_ADDR_W, 10, ROM word-address width
- RAM_ADDR_W, 13, RAM word-address width
- ROM_BASE, 0, first ROM word copied
- RAM_BASE, 0, first RAM word written
- COPY_LEN, 1024, words copied; 0 is legal; range 0 to 2^ROM_ADDR_W
- AUTO_START, 1, 1 = copy begins automatically after reset
- clk_i  in  1  single clock, rising edge
- cke_i  in  1  clock enable; state advances only when 1
- arst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle copy request
- busy_o  out  1  copy in progress
- done_o  out  1  last copy completed
- soc_hold_o  out  1  SoC must stall or stay in reset
- rom_en_o  out  1  ROM read enable
- rom_addr_o  out  ROM_ADDR_W  ROM word address
- rom_r_data_i  in  DATA_W  ROM data, valid the cycle after the enable
- soc_r_en_i, soc_r_addr_i, soc_w_data_i, soc_w_strb_i (DATA_W/8), soc_w_addr_i  in  SoC-side RAM request
- soc_r_data_o  out  DATA_W  read data returned to the SoC
- ram_r_en_o, ram_r_addr_o, ram_w_data_o, ram_w_strb_o, ram_w_addr_o  out  RAM-side request
- ram_r_data_i  in  DATA_W  RAM read data

## Operation
- States: START, COPY, PASS.
  - Reset state is START if AUTO_START=1, otherwise PASS.
- START: soc_hold_o=1.
  - On the next cke cycle, go to COPY.
  - If COPY_LEN=0, go to PASS instead and set done_o=1.
- COPY: phase counter p runs 0..COPY_LEN, incrementing on every cke cycle.
  - Read side: if p<COPY_LEN, rom_en_o=1 and rom_addr_o=ROM_BASE+p, truncated to ROM_ADDR_W.
  - Write side: if p≥1, ram_w_strb_o = all ones, ram_w_addr_o = RAM_BASE+p-1 (truncated to RAM_ADDR_W), ram_w_data_o = rom_r_data_i.
  - Read side of the RAM: ram_r_en_o=0.
  - Exit: when p=COPY_LEN, go to PASS and set done_o=1.
- PASS: all ram_* outputs equal the matching soc_* inputs combinationally; soc_r_data_o = ram_r_data_i.
- start_i in PASS with cke_i=1 returns to START and clears done_o.
- start_i in START or COPY is ignored.
- soc_r_data_o is 0 outside PASS. SoC write strobes and read enables never reach the RAM outside PASS.
- busy_o = state is COPY. soc_hold_o = state is not PASS.
- cke_i=0: all registers hold. In COPY, rom_en_o and ram_w_strb_o are forced 0, so the ROM output register keeps the pending word. The interrupted write completes on the first cycle cke_i returns high.
- Address arithmetic: unsigned, wraps modulo 2^width. RAM_BASE+COPY_LEN beyond the RAM depth wraps to word 0.

## Timing
- Reset values:
  - state = START or PASS as above; p=0; done_o=0; busy_o=0.
  - soc_hold_o = 1 if AUTO_START, else 0.
  - rom_en_o=0; ram_w_strb_o=0; ram_r_en_o=0; soc_r_data_o=0.
  - In PASS, outputs follow the pass-through inputs.
- Reset asserted mid-copy aborts immediately: writes stop asynchronously and done_o=0. The RAM keeps any partial image.
- Copy duration:
  - START takes 1 cycle; COPY takes COPY_LEN+1 cke cycles.
  - soc_hold_o deasserts COPY_LEN+2 cke cycles after START is entered.
- ROM latency is 1 cycle: word k is issued in COPY cycle k and written in cycle k+1. Exactly one RAM write per COPY cycle with p≥1.
- done_o and busy_o are registered. done_o rises in the same cycle soc_hold_o falls.
- PASS path latency is 0 cycles (combinational). Read data timing is the RAM's own.

## Test plan
- Reset, LEN=8, ROM word i = 0xA5000000+i:
  - RAM words 0..7 hold those values.
  - busy_o high for exactly 9 cycles; soc_hold_o falls on the 10th cycle after reset release.
  - Exactly 8 write strobes of 0xF.
- In PASS, SoC write 0x12345678 strobe 0x3 to addr 5, then read addr 5 → RAM sees identical signals; soc_r_data_o returns the RAM data.
- COPY_LEN=0 → done_o=1 one cycle after reset; zero ROM reads and zero RAM writes.
- cke_i low for 3 cycles at p=4 (LEN=8):
  - no strobes while low;
  - the write to RAM_BASE+3 occurs on resume;
  - final image is correct; total active cycles still 9.
- RAM_BASE=0x1FFE, LEN=4 → writes land at 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- arst_i pulse at p=3, AUTO_START=1 → outputs go to reset values immediately. The copy restarts from word 0 and completes correctly. start_i during COPY has no effect.
